// File: rtl/key_schedule_ctrl_if.sv
// Bus bundle between the AES datapath and the shared round-key controller.
// It carries the key load handshake, the status flags, and the indexed
// round-key read port.
// The controller sits on the slave side and the datapath on the master side.
interface key_schedule_ctrl_if #(
  parameter int KW = 128
);
  logic [KW-1:0] key_in;
  logic          key_load;
  logic          key_ready;
  logic          busy;
  logic          done;
  logic [3:0]    rd_round;
  logic [KW-1:0] rd_key;
  logic          rd_valid;

  modport master (
    output key_in, key_load, rd_round,
    input  key_ready, busy, done, rd_key, rd_valid
  );

  modport slave (
    input  key_in, key_load, rd_round,
    output key_ready, busy, done, rd_key, rd_valid
  );
endinterface

// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule controller.
// It captures a cipher key and runs the single-round KeyGeneration step once
// per clock for NR rounds. All NR+1 round keys are held in a register bank,
// and the datapath reads them back through a registered, indexed port.
// Optional macro KEY_SCHED_REVERSE_EN: the read port returns keys in
// decryption order, so rd_round=i gives bank[NR-i]. Without the macro the
// read port uses encryption order.

// One round of AES-128 key expansion: rcon index rc, previous round key in,
// next round key out. Words are MSB-first (w0 = key[127:96]).
module KeyGeneration (
  input  logic [3:0]   rc,
  input  logic [127:0] key,
  output logic [127:0] keyout
);

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box computed as multiplicative inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
    x2   = gfMul(x, x);
    x4   = gfMul(x2, x2);
    x8   = gfMul(x4, x4);
    x16  = gfMul(x8, x8);
    x32  = gfMul(x16, x16);
    x64  = gfMul(x32, x32);
    x128 = gfMul(x64, x64);
    inv  = gfMul(gfMul(gfMul(x2, x4), gfMul(x8, x16)), gfMul(gfMul(x32, x64), x128));
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Round constant; only rc 0..9 are meaningful for AES-128
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [31:0] w0, w1, w2, w3, rotW, subW, tempW, n0, n1, n2, n3;

  // Next round key: RotWord/SubWord/rcon on w3, then the chained XORs
  always_comb begin
    w0    = key[127:96];
    w1    = key[95:64];
    w2    = key[63:32];
    w3    = key[31:0];
    rotW  = {w3[23:0], w3[31:24]};
    subW  = {sbox(rotW[31:24]), sbox(rotW[23:16]), sbox(rotW[15:8]), sbox(rotW[7:0])};
    tempW = subW ^ {rcon(rc), 24'h000000};
    n0    = w0 ^ tempW;
    n1    = w1 ^ n0;
    n2    = w2 ^ n1;
    n3    = w3 ^ n2;
    keyout = {n0, n1, n2, n3};
  end

endmodule

module key_schedule_ctrl #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input logic clk,
  input logic rst_n,
  key_schedule_ctrl_if.slave bus
);

  localparam logic [3:0] NR4 = 4'(NR);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  state_t        state_q;
  logic [3:0]    rc_q;
  logic [KW-1:0] bank_q [0:NR];
  logic          key_ready_q;
  logic          busy_q;
  logic          done_q;
  logic [KW-1:0] rd_key_q;
  logic          rd_valid_q;
  logic [KW-1:0] keyout_d;
  logic [3:0]    rdIdx;

  KeyGeneration u_keygen (
    .rc     (rc_q),
    .key    (bank_q[rc_q]),
    .keyout (keyout_d)
  );

`ifdef KEY_SCHED_REVERSE_EN
  assign rdIdx = NR4 - bus.rd_round;
`else
  assign rdIdx = bus.rd_round;
`endif

  assign bus.key_ready = key_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_key    = rd_key_q;
  assign bus.rd_valid  = rd_valid_q;

  // Expansion FSM: capture a key, fill bank[1..NR] one round per clock, then flag completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rc_q        <= 4'd0;
      key_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i <= NR; i++) bank_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, READY: begin
          if (bus.key_load && key_ready_q) begin
            bank_q[0]   <= bus.key_in;
            rc_q        <= 4'd0;
            state_q     <= EXPAND;
            key_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        EXPAND: begin
          bank_q[rc_q + 4'd1] <= keyout_d;
          rc_q                <= rc_q + 4'd1;
          if (rc_q == NR4 - 4'd1) begin
            state_q     <= READY;
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          key_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Registered read port: serves stored keys only once the bank is complete
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_key_q   <= '0;
      rd_valid_q <= 1'b0;
    end else if (state_q == READY && bus.rd_round <= NR4) begin
      rd_key_q   <= bank_q[rdIdx];
      rd_valid_q <= 1'b1;
    end else begin
      rd_key_q   <= '0;
      rd_valid_q <= 1'b0;
    end
  end

endmodule
